i2c_expander_target: RTL and testbench



---
 rtl/i2c_expander_target_if.sv | 9 +
 rtl/i2c_expander_target.sv | 233 +++++++++++++++++++++++
 tb/tb_i2c_expander_target.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_expander_target_if.sv
// I2C pin bundle between a bus initiator (scl/sda driver) and the expander target.
interface i2c_expander_target_if;
  logic scl;
  logic sda_in;
  logic sda_oe;

  modport master (output scl, output sda_in, input sda_oe);
  modport slave  (input scl, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_expander_target.sv
// I2C target emulating an 8-bit GPIO expander with an 11-register map.
// Bus lines are synchronized and glitch-filtered on the system clock; SCL is never stretched.
module i2c_expander_target #(
  parameter logic [6:0]  ADDR = 7'h20,
  parameter int unsigned FILT = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  i2c_expander_target_if.slave bus,
  input  logic [7:0]           gpio_in,
  output logic [7:0]           gpio_out,
  output logic [7:0]           gpio_oe,
  output logic                 busy
);
  localparam int unsigned FCW = (FILT > 1) ? $clog2(FILT) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_e;

  // Line index 1 = SCL, 0 = SDA; idle bus level is high.
  logic [1:0]     sy1_q, sy2_q, filt_q, prev_q;
  logic [FCW-1:0] fcnt_q [2];
  logic [7:0]     gs1_q, gs2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sy1_q     <= 2'b11;
      sy2_q     <= 2'b11;
      filt_q    <= 2'b11;
      prev_q    <= 2'b11;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
      gs1_q     <= 8'h00;
      gs2_q     <= 8'h00;
    end else begin
      sy1_q  <= {bus.scl, bus.sda_in};
      sy2_q  <= sy1_q;
      prev_q <= filt_q;
      gs1_q  <= gpio_in;
      gs2_q  <= gs1_q;
      for (int i = 0; i < 2; i++) begin
        if (sy2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FCW'(FILT - 1)) begin
          filt_q[i] <= sy2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + FCW'(1);
        end
      end
    end
  end

  logic sda_f, scl_rise, scl_fall, start_det, stop_det;
  assign sda_f     = filt_q[0];
  assign scl_rise  =  filt_q[1] & ~prev_q[1];
  assign scl_fall  = ~filt_q[1] &  prev_q[1];
  assign start_det = filt_q[1] & prev_q[1] & ~filt_q[0] &  prev_q[0];
  assign stop_det  = filt_q[1] & prev_q[1] &  filt_q[0] & ~prev_q[0];

  state_e     state_q;
  logic [2:0] cnt_q;
  logic [6:0] sh_q;
  logic [3:0] ptr_q;
  logic       rw_q, ack_on_q, sda_oe_q, busy_q;
  logic [7:0] iodir_q, ipol_q, gpinten_q, defval_q, intcon_q, iocon_q, gppu_q, olat_q;
  logic [7:0] gpio_out_q, gpio_oe_q;
  logic [7:0] byte_in, rd_data;
  logic [3:0] ptr_nxt;

  assign byte_in = {sh_q, sda_f};
  assign ptr_nxt = iocon_q[5] ? ptr_q : ((ptr_q >= 4'hA) ? 4'h0 : ptr_q + 4'h1);

  // Read mux for the byte about to be shifted out.
  always_comb begin
    rd_data = 8'h00;
    case (ptr_q)
      4'h0:    rd_data = iodir_q;
      4'h1:    rd_data = ipol_q;
      4'h2:    rd_data = gpinten_q;
      4'h3:    rd_data = defval_q;
      4'h4:    rd_data = intcon_q;
      4'h5:    rd_data = iocon_q;
      4'h6:    rd_data = gppu_q;
      4'h9:    rd_data = gs2_q ^ ipol_q;
      4'hA:    rd_data = olat_q;
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      sh_q       <= 7'd0;
      ptr_q      <= 4'h0;
      rw_q       <= 1'b0;
      ack_on_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      iodir_q    <= 8'hFF;
      ipol_q     <= 8'h00;
      gpinten_q  <= 8'h00;
      defval_q   <= 8'h00;
      intcon_q   <= 8'h00;
      iocon_q    <= 8'h00;
      gppu_q     <= 8'h00;
      olat_q     <= 8'h00;
      gpio_out_q <= 8'h00;
      gpio_oe_q  <= 8'h00;
    end else begin
      gpio_out_q <= olat_q;
      gpio_oe_q  <= ~iodir_q;
      if (start_det) begin
        state_q  <= S_ADDR;
        cnt_q    <= 3'd0;
        ack_on_q <= 1'b0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (stop_det) begin
        state_q  <= S_IDLE;
        cnt_q    <= 3'd0;
        ack_on_q <= 1'b0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (scl_rise) begin
        case (state_q)
          S_ADDR, S_PTR, S_WDATA: begin
            sh_q  <= byte_in[6:0];
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              cnt_q    <= 3'd0;
              ack_on_q <= 1'b0;
              case (state_q)
                S_ADDR: begin
                  if (byte_in[7:1] == ADDR) begin
                    state_q <= S_ADDR_ACK;
                    rw_q    <= byte_in[0];
                    busy_q  <= 1'b1;
                  end else begin
                    state_q <= S_IGNORE;
                  end
                end
                S_PTR: begin
                  ptr_q   <= byte_in[3:0];
                  state_q <= S_PTR_ACK;
                end
                default: begin
                  case (ptr_q)
                    4'h0:       iodir_q   <= byte_in;
                    4'h1:       ipol_q    <= byte_in;
                    4'h2:       gpinten_q <= byte_in;
                    4'h3:       defval_q  <= byte_in;
                    4'h4:       intcon_q  <= byte_in;
                    4'h5:       iocon_q   <= byte_in;
                    4'h6:       gppu_q    <= byte_in;
                    4'h9, 4'hA: olat_q    <= byte_in;
                    default: ;
                  endcase
                  ptr_q   <= ptr_nxt;
                  state_q <= S_WDATA_ACK;
                end
              endcase
            end
          end
          S_RDATA: begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              cnt_q    <= 3'd0;
              ack_on_q <= 1'b0;
              state_q  <= S_RDATA_ACK;
            end
          end
          // Initiator's ACK/NACK is sampled on the 9th rise.
          S_RDATA_ACK: begin
            if (ack_on_q) begin
              if (sda_f) state_q <= S_IGNORE;
              else       ptr_q   <= ptr_nxt;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state_q)
          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
            if (!ack_on_q) begin
              sda_oe_q <= 1'b1;
              ack_on_q <= 1'b1;
            end else begin
              sda_oe_q <= 1'b0;
              ack_on_q <= 1'b0;
              cnt_q    <= 3'd0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                sh_q     <= rd_data[6:0];
                sda_oe_q <= ~rd_data[7];
                state_q  <= S_RDATA;
              end else if (state_q == S_ADDR_ACK) begin
                state_q <= S_PTR;
              end else begin
                state_q <= S_WDATA;
              end
            end
          end
          S_RDATA: begin
            sda_oe_q <= ~sh_q[6];
            sh_q     <= {sh_q[5:0], 1'b0};
          end
          S_RDATA_ACK: begin
            if (!ack_on_q) begin
              sda_oe_q <= 1'b0;
              ack_on_q <= 1'b1;
            end else begin
              sh_q     <= rd_data[6:0];
              sda_oe_q <= ~rd_data[7];
              ack_on_q <= 1'b0;
              cnt_q    <= 3'd0;
              state_q  <= S_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign gpio_out   = gpio_out_q;
  assign gpio_oe    = gpio_oe_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_expander_target.sv
// Bench for i2c_expander_target: bit-level I2C initiator plus a register-map reference model.
module tb_i2c_expander_target;
  localparam logic [6:0]  TADDR = 7'h20;
  localparam int unsigned HQ    = 12;

  logic       clk = 1'b0;
  logic       reset_n, scl_m, sda_m, busy;
  logic [7:0] gpio_in, gpio_out, gpio_oe;

  i2c_expander_target_if bus();
  assign bus.scl    = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  i2c_expander_target #(.ADDR(TADDR), .FILT(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int oe_cnt = 0;
  always @(posedge clk) if (bus.sda_oe === 1'b1) oe_cnt = oe_cnt + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Reference model: register file indexed by pointer, plus the pointer itself.
  logic [7:0] m_reg [0:10];
  logic [3:0] m_ptr;

  function automatic void m_reset();
    for (int i = 0; i <= 10; i++) m_reg[i] = 8'h00;
    m_reg[0] = 8'hFF;
    m_ptr    = 4'h0;
  endfunction

  function automatic logic [7:0] m_read(input logic [3:0] p);
    if (p <= 4'h6 || p == 4'hA) return m_reg[p];
    if (p == 4'h9) return gpio_in ^ m_reg[1];
    return 8'h00;
  endfunction

  function automatic logic [3:0] m_adv(input logic [3:0] p);
    if (m_reg[5][5]) return p;
    return (p >= 4'hA) ? 4'h0 : p + 4'h1;
  endfunction

  function automatic void m_write(input logic [3:0] p, input logic [7:0] d);
    if (p <= 4'h6) m_reg[p] = d;
    else if (p == 4'h9 || p == 4'hA) m_reg[10] = d;
  endfunction

  logic [7:0] wdat [4];
  logic [7:0] rdat [4];

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, input bit glitch, output logic seen);
    wclk(5);
    sda_m = b;
    if (glitch) begin
      wclk(1); scl_m = 1'b1; wclk(1); scl_m = 1'b0; wclk(HQ - 7);
    end else begin
      wclk(HQ - 5);
    end
    scl_m = 1'b1;
    wclk(HQ / 2);
    seen = bus.sda_in;
    wclk(HQ / 2);
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    wclk(5); sda_m = 1'b1; wclk(HQ - 5); scl_m = 1'b1; wclk(HQ); sda_m = 1'b0; wclk(HQ); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wclk(5); sda_m = 1'b0; wclk(HQ - 5); scl_m = 1'b1; wclk(HQ); sda_m = 1'b1; wclk(HQ);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit glitch, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], glitch && (i == 4), s);
    bit_xfer(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input bit ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, 1'b0, s);
      b[i] = s;
    end
    bit_xfer(~ack, 1'b0, s);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] pb, input int n, input bit glitch);
    logic ack, hit;
    logic [3:0] nx;
    int oe0;
    hit = (a == TADDR);
    oe0 = oe_cnt;
    i2c_start();
    send_byte({a, 1'b0}, 1'b0, ack);
    chk("wr_addr_ack", ack, hit);
    chk("wr_busy", busy, hit);
    send_byte(pb, 1'b0, ack);
    chk("wr_ptr_ack", ack, hit);
    if (hit) m_ptr = pb[3:0];
    for (int i = 0; i < n; i++) begin
      send_byte(wdat[i], glitch && (i == 0), ack);
      chk("wr_data_ack", ack, hit);
      if (hit) begin
        nx = m_adv(m_ptr);
        m_write(m_ptr, wdat[i]);
        m_ptr = nx;
      end
    end
    i2c_stop();
    if (!hit) chk("wr_no_drive", 8'(oe_cnt - oe0), 8'h00);
    chk("wr_busy_end", busy, 1'b0);
    chk("gpio_out", gpio_out, m_reg[10]);
    chk("gpio_oe", gpio_oe, ~m_reg[0]);
  endtask

  task automatic do_read(input logic [6:0] a, input bit set_ptr, input logic [7:0] pb, input int n);
    logic ack, hit;
    logic [7:0] b;
    hit = (a == TADDR);
    i2c_start();
    if (set_ptr) begin
      send_byte({a, 1'b0}, 1'b0, ack);
      chk("rd_waddr_ack", ack, hit);
      send_byte(pb, 1'b0, ack);
      chk("rd_ptr_ack", ack, hit);
      if (hit) m_ptr = pb[3:0];
      i2c_start();
    end
    send_byte({a, 1'b1}, 1'b0, ack);
    chk("rd_addr_ack", ack, hit);
    chk("rd_busy", busy, hit);
    if (hit) begin
      for (int i = 0; i < n; i++) begin
        recv_byte(i < n - 1, b);
        rdat[i] = b;
        chk("rd_data", b, m_read(m_ptr));
        if (i < n - 1) m_ptr = m_adv(m_ptr);
      end
    end
    i2c_stop();
    chk("rd_busy_end", busy, 1'b0);
  endtask

  initial begin
    logic ack, s;
    logic [6:0] ra;
    int n;
    reset_n = 1'b0;
    scl_m   = 1'b1;
    sda_m   = 1'b1;
    gpio_in = 8'h00;
    m_reset();
    wclk(5);
    reset_n = 1'b1;
    wclk(5);
    chk("rst_sda_oe", bus.sda_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_gpio_out", gpio_out, 8'h00);
    chk("rst_gpio_oe", gpio_oe, 8'h00);

    wdat[0] = 8'hF8; do_write(TADDR, 8'h00, 1, 1'b0);
    chk("iodir_f8", gpio_oe, 8'h07);
    wdat[0] = 8'h05; do_write(TADDR, 8'h09, 1, 1'b0);
    chk("olat_via_gpio", gpio_out, 8'h05);
    wdat[0] = 8'h24; do_write(TADDR, 8'h05, 1, 1'b0);
    wdat[0] = 8'h03; do_write(TADDR, 8'h0A, 1, 1'b0);
    chk("olat_direct", gpio_out, 8'h03);

    gpio_in = 8'hA8;
    do_read(TADDR, 1'b1, 8'h09, 1);
    chk("gpio_ipol0", rdat[0], 8'hA8);
    wdat[0] = 8'hFF; do_write(TADDR, 8'h01, 1, 1'b0);
    do_read(TADDR, 1'b1, 8'h09, 1);
    chk("gpio_ipolff", rdat[0], 8'h57);
    wdat[0] = 8'h00; do_write(TADDR, 8'h01, 1, 1'b0);
    wdat[0] = 8'h00; do_write(TADDR, 8'h05, 1, 1'b0);

    do_read(TADDR, 1'b1, 8'h09, 3);
    chk("seq_gpio", rdat[0], 8'hA8);
    chk("seq_olat", rdat[1], 8'h03);
    chk("seq_wrap_iodir", rdat[2], 8'hF8);
    wdat[0] = 8'h20; do_write(TADDR, 8'h05, 1, 1'b0);
    do_read(TADDR, 1'b1, 8'h09, 3);
    chk("hold_0", rdat[0], 8'hA8);
    chk("hold_1", rdat[1], 8'hA8);
    chk("hold_2", rdat[2], 8'hA8);
    wdat[0] = 8'h00; do_write(TADDR, 8'h05, 1, 1'b0);

    wdat[0] = 8'h00; do_write(7'h21, 8'h00, 1, 1'b0);
    chk("miss_iodir", gpio_oe, 8'h07);

    wdat[0] = 8'h3C; do_write(TADDR, 8'h0A, 1, 1'b1);
    chk("glitch_olat", gpio_out, 8'h3C);

    // Partial data byte cut by STOP must not write.
    i2c_start();
    send_byte({TADDR, 1'b0}, 1'b0, ack);
    send_byte(8'h0A, 1'b0, ack);
    m_ptr = 4'hA;
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, 1'b0, s);
    i2c_stop();
    wclk(4);
    chk("partial_olat", gpio_out, 8'h3C);

    // Reset while the target is driving a zero data bit.
    gpio_in = 8'h00;
    do_write(TADDR, 8'h09, 0, 1'b0);
    i2c_start();
    send_byte({TADDR, 1'b1}, 1'b0, ack);
    chk("rst_rd_ack", ack, 1'b1);
    wclk(8);
    chk("rst_pre_oe", bus.sda_oe, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_oe", bus.sda_oe, 1'b0);
    wclk(2);
    chk("rst_mid_gpio_oe", gpio_oe, 8'h00);
    chk("rst_mid_gpio_out", gpio_out, 8'h00);
    chk("rst_mid_busy", busy, 1'b0);
    m_reset();
    scl_m = 1'b1; wclk(2); sda_m = 1'b1; wclk(4);
    reset_n = 1'b1;
    wclk(10);
    wdat[0] = 8'h5A; do_write(TADDR, 8'h0A, 1, 1'b0);
    do_read(TADDR, 1'b1, 8'h0A, 1);
    chk("post_rst_read", rdat[0], 8'h5A);

    for (int k = 0; k < 20; k++) begin
      gpio_in = 8'($urandom);
      ra = ($urandom_range(0, 5) == 0) ? 7'h21 : TADDR;
      n  = $urandom_range(1, 3);
      case ($urandom_range(0, 2))
        0: begin
          for (int i = 0; i < n; i++) wdat[i] = 8'($urandom);
          do_write(ra, 8'($urandom), n, 1'b0);
        end
        1: do_read(ra, 1'b1, 8'($urandom), n);
        default: do_read(ra, 1'b0, 8'h00, n);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
